// File: rtl/interrupt_controller.sv
// Four-source fixed-priority interrupt controller with edge-latched pending bits,
// a mask register and a single-level ASSERT/SERVICE handshake (no nesting).
module interrupt_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] irq_src,
   input  logic       mask_we,
   input  logic [3:0] mask_wdata,
   input  logic       ack,
   input  logic       eoi,
   output logic       irq,
   output logic [1:0] irq_id,
   output logic [3:0] pending,
   output logic [3:0] in_service,
   output logic [3:0] mask
);

   // Handshake: irq is high for exactly the ASSERT state; ack is honoured only in
   // ASSERT, eoi only in SERVICE, and everything else on those lines is ignored.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;
   logic [3:0] src_q;
   logic [3:0] pend_q;
   logic [3:0] mask_q;
   logic [1:0] id_q;
   logic [3:0] rise;
   logic [3:0] eligible;
   logic [3:0] id_onehot;
   logic [3:0] ack_clear;
   logic [1:0] sel_id;
   logic       ack_take;
   logic       mask_drop;

   assign rise      = irq_src & ~src_q;
   assign eligible  = pend_q & ~mask_q;
   assign id_onehot = 4'b0001 << id_q;
   assign ack_take  = (state == ASSERT) && ack;
   assign mask_drop = (state == ASSERT) && !ack && mask_we && mask_wdata[id_q];
   assign ack_clear = ack_take ? id_onehot : 4'b0000;

   // Scanning from the top down leaves the lowest eligible index selected.
   always_comb begin
      sel_id = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (eligible[i]) sel_id = 2'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (eligible != 4'b0000) state_next = ASSERT;
         ASSERT: begin
            if (ack_take)       state_next = SERVICE;
            else if (mask_drop) state_next = IDLE;
         end
         SERVICE: if (eoi) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A new edge on the acknowledged source re-sets its pending bit in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q  <= 4'b0000;
         pend_q <= 4'b0000;
         mask_q <= 4'b0000;
         id_q   <= 2'b00;
      end else begin
         src_q  <= irq_src;
         pend_q <= (pend_q & ~ack_clear) | rise;
         if (mask_we) mask_q <= mask_wdata;
         if (state == IDLE && eligible != 4'b0000) id_q <= sel_id;
      end
   end

   always_comb begin
      irq        = (state == ASSERT);
      irq_id     = (state == IDLE) ? 2'b00 : id_q;
      in_service = (state == SERVICE) ? id_onehot : 4'b0000;
      pending    = pend_q;
      mask       = mask_q;
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus a randomized phase, all
// checked against a behavioural model of the controller's rules.
module tb_interrupt_controller;

  logic       clk;
  logic       rst;
  logic [3:0] irq_src;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] in_service;
  logic [3:0] mask;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: 0 = idle, 1 = asserting, 2 = in service.
  int         m_state;
  logic [3:0] m_srcq;
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic [1:0] m_id;

  interrupt_controller dut (
    .clk        (clk),
    .rst        (rst),
    .irq_src    (irq_src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .eoi        (eoi),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service),
    .mask       (mask)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] s, input logic we,
                            input logic [3:0] wd, input logic a, input logic e);
    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] nxt_pend;
    if (r) begin
      m_state = 0;
      m_srcq  = 4'b0000;
      m_pend  = 4'b0000;
      m_mask  = 4'b0000;
      m_id    = 2'b00;
    end else begin
      rise     = s & ~m_srcq;
      elig     = m_pend & ~m_mask;
      nxt_pend = m_pend | rise;
      if (m_state == 0) begin
        if (elig != 4'b0000) begin
          for (int i = 3; i >= 0; i--) if (elig[i]) m_id = 2'(i);
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (a) begin
          nxt_pend[m_id] = rise[m_id];
          m_state = 2;
        end else if (we && wd[m_id]) begin
          m_state = 0;
        end
      end else if (e) begin
        m_state = 0;
      end
      m_pend = nxt_pend;
      if (we) m_mask = wd;
      m_srcq = s;
    end
  endtask

  task automatic check_model();
    chk("irq", {3'b000, irq}, {3'b000, m_state == 1});
    chk("irq_id", {2'b00, irq_id}, (m_state == 0) ? 4'b0000 : {2'b00, m_id});
    chk("pending", pending, m_pend);
    chk("in_service", in_service, (m_state == 2) ? (4'b0001 << m_id) : 4'b0000);
    chk("mask", mask, m_mask);
  endtask

  // Driver: inputs change on the falling edge, outputs sampled 1 time unit after rise.
  task automatic cyc(input logic r, input logic [3:0] s, input logic we,
                     input logic [3:0] wd, input logic a, input logic e);
    @(negedge clk);
    rst = r; irq_src = s; mask_we = we; mask_wdata = wd; ack = a; eoi = e;
    @(posedge clk);
    model_step(r, s, we, wd, a, e);
    #1;
    check_model();
  endtask

  task automatic idle();                    cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0); endtask
  task automatic pulse(input logic [3:0] s); cyc(1'b0, s, 1'b0, 4'b0000, 1'b0, 1'b0); endtask
  task automatic do_ack(input logic [3:0] s); cyc(1'b0, s, 1'b0, 4'b0000, 1'b1, 1'b0); endtask
  task automatic do_eoi();                  cyc(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1); endtask
  task automatic wmask(input logic [3:0] v); cyc(1'b0, 4'b0000, 1'b1, v, 1'b0, 1'b0); endtask

  logic [1:0] exp_ids [3];

  initial begin
    rst = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; eoi = 1'b0;
    m_state = 0; m_srcq = '0; m_pend = '0; m_mask = '0; m_id = '0;

    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    cyc(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("reset_irq", {3'b000, irq}, 4'b0000);
    chk("reset_pending", pending, 4'b0000);

    // Quiet sources
    repeat (10) idle();
    chk("idle_irq", {3'b000, irq}, 4'b0000);
    chk("idle_id", {2'b00, irq_id}, 4'b0000);
    chk("idle_pending", pending, 4'b0000);

    // Single source 2
    pulse(4'b0100);
    chk("single_pending", pending, 4'b0100);
    chk("single_irq_early", {3'b000, irq}, 4'b0000);
    idle();
    chk("single_irq", {3'b000, irq}, 4'b0001);
    chk("single_id", {2'b00, irq_id}, 4'b0010);
    do_ack(4'b0000);
    chk("single_ack_pending", pending, 4'b0000);
    chk("single_ack_insvc", in_service, 4'b0100);
    chk("single_ack_irq", {3'b000, irq}, 4'b0000);
    do_eoi();
    chk("single_eoi_insvc", in_service, 4'b0000);

    // Priority order 1, 2, 3
    pulse(4'b1110);
    exp_ids = '{2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("prio_irq", {3'b000, irq}, 4'b0001);
      chk("prio_id", {2'b00, irq_id}, {2'b00, exp_ids[k]});
      do_ack(4'b0000);
      do_eoi();
    end
    chk("prio_pending_end", pending, 4'b0000);

    // Masked source stays pending until unmasked
    wmask(4'b0001);
    pulse(4'b0001);
    chk("mask_pending", pending, 4'b0001);
    idle();
    chk("mask_irq_low", {3'b000, irq}, 4'b0000);
    wmask(4'b0000);
    idle();
    chk("unmask_irq", {3'b000, irq}, 4'b0001);
    chk("unmask_id", {2'b00, irq_id}, 4'b0000);
    do_ack(4'b0000);
    do_eoi();

    // No preemption of an in-service source 3
    pulse(4'b1000);
    idle();
    do_ack(4'b0000);
    pulse(4'b0001);
    chk("nopre_pending", pending, 4'b0001);
    idle();
    chk("nopre_irq", {3'b000, irq}, 4'b0000);
    chk("nopre_id", {2'b00, irq_id}, 4'b0011);
    do_eoi();
    chk("nopre_eoi_irq", {3'b000, irq}, 4'b0000);
    idle();
    chk("nopre_after_irq", {3'b000, irq}, 4'b0001);
    chk("nopre_after_id", {2'b00, irq_id}, 4'b0000);
    do_ack(4'b0000);
    do_eoi();

    // Masking the presented source drops back to idle
    pulse(4'b0100);
    idle();
    wmask(4'b0100);
    chk("maskdrop_irq", {3'b000, irq}, 4'b0000);
    chk("maskdrop_pending", pending, 4'b0100);
    wmask(4'b0000);
    idle();
    do_ack(4'b0000);
    do_eoi();

    // New edge coincident with ack keeps the bit pending
    pulse(4'b0010);
    idle();
    do_ack(4'b0010);
    chk("coinc_pending", pending, 4'b0010);
    chk("coinc_insvc", in_service, 4'b0010);
    do_eoi();
    idle();
    chk("coinc_reassert_id", {2'b00, irq_id}, 4'b0001);
    do_ack(4'b0000);
    do_eoi();

    // Reset while in service
    wmask(4'b1000);
    pulse(4'b1100);
    idle();
    do_ack(4'b0000);
    chk("svc_before_rst", in_service, 4'b0100);
    cyc(1'b1, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
    chk("rst_irq", {3'b000, irq}, 4'b0000);
    chk("rst_id", {2'b00, irq_id}, 4'b0000);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_insvc", in_service, 4'b0000);
    chk("rst_mask", mask, 4'b0000);
    cyc(1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("held_src_edge", pending, 4'b0001);
    idle();
    do_ack(4'b0000);
    do_eoi();

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      cyc(1'b0 | ($urandom_range(0, 99) == 0),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 9) == 0),
          4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
